// File: rtl/squeeze_stage.sv
// Squeeze stage: unloads permutation rate words W bits at a time,
// requesting further permutations until the requested length is emitted.
module squeeze_stage #(
    parameter int W     = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [LEN_W-1:0] out_len_i,
    input  logic             abort_i,
    input  logic [1343:0]    block_in,
    input  logic             block_valid_i,
    output logic             block_ready_o,
    output logic             squeeze_req_o,
    output logic [W-1:0]     data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             busy_o
);

    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam int D128 = RATE_SHAKE128 / W;
    localparam int D256 = RATE_SHAKE256 / W;
    localparam int WL_W = $clog2(D128 + 1);
    localparam int BLK_W = RATE_SHAKE128 - W;

    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        DUMP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [WL_W-1:0]   words_left_q;
    logic [BLK_W-1:0]  blk_q;
    logic [WL_W-1:0]   depth;
    logic              start_ok;
    logic              load;
    logic              xfer;
    logic              rem_one;
    logic              wl_one;
    logic              squeeze_d;

    assign depth = (mode_q == SHAKE256_MODE_VEC) ?
                   WL_W'(D256) : WL_W'(D128);

    assign valid_o       = (state_q == DUMP);
    assign block_ready_o = (state_q == WAIT_BLOCK);
    assign busy_o        = (state_q != IDLE);
    assign rem_one       = (remaining_q == LEN_W'(1));
    assign wl_one        = (words_left_q == WL_W'(1));
    assign last_o        = valid_o && rem_one;

    // Abort wins over every other action in the same cycle.
    assign start_ok = (state_q == IDLE) && start_i &&
                      (out_len_i != '0) && !abort_i;
    assign load     = block_ready_o && block_valid_i && !abort_i;
    assign xfer     = valid_o && ready_i && !abort_i;
    assign squeeze_d = xfer && !rem_one && wl_one;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = WAIT_BLOCK;
            end
            WAIT_BLOCK: begin
                if (load) state_d = DUMP;
            end
            DUMP: begin
                if (xfer && rem_one) state_d = IDLE;
                else if (xfer && wl_one) state_d = WAIT_BLOCK;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q        <= SHAKE128_MODE_VEC;
            remaining_q   <= '0;
            words_left_q  <= '0;
            blk_q         <= '0;
            data_o        <= '0;
            squeeze_req_o <= 1'b0;
        end else begin
            squeeze_req_o <= squeeze_d;
            if (start_ok) begin
                mode_q      <= mode_i;
                remaining_q <= out_len_i;
            end
            if (load) begin
                data_o       <= block_in[W-1:0];
                blk_q        <= block_in[RATE_SHAKE128-1:W];
                words_left_q <= depth;
            end else if (xfer) begin
                remaining_q  <= remaining_q - LEN_W'(1);
                words_left_q <= words_left_q - WL_W'(1);
                // Output word holds once the job or the block runs out.
                if (!rem_one && !wl_one) begin
                    data_o <= blk_q[W-1:0];
                    blk_q  <= {{W{1'b0}}, blk_q[BLK_W-1:W]};
                end
            end
        end
    end

endmodule

// File: tb/tb_squeeze_stage.sv
// Directed self-checking bench for squeeze_stage at W=64.
module tb_squeeze_stage;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [15:0]   out_len_i = '0;
    logic          abort_i = 1'b0;
    logic [1343:0] block_in = '0;
    logic          block_valid_i = 1'b0;
    logic          block_ready_o;
    logic          squeeze_req_o;
    logic [63:0]   data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          last_o;
    logic          busy_o;

    int checks = 0;
    int fails = 0;
    int sq_cnt = 0;

    squeeze_stage #(.W(64), .LEN_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .mode_i(mode_i),
        .out_len_i(out_len_i),
        .abort_i(abort_i),
        .block_in(block_in),
        .block_valid_i(block_valid_i),
        .block_ready_o(block_ready_o),
        .squeeze_req_o(squeeze_req_o),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .last_o(last_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst && squeeze_req_o) sq_cnt++;

    task automatic make_block(input logic [63:0] base,
                              output logic [1343:0] b);
        b = '0;
        for (int i = 0; i < 21; i++) b[i*64 +: 64] = base + 64'(i);
    endtask

    task automatic start_job(input logic [1:0] m, input logic [15:0] n);
        start_i = 1'b1;
        mode_i = m;
        out_len_i = n;
        @(negedge clk);
        start_i = 1'b0;
        mode_i = 2'b00;
        out_len_i = '0;
    endtask

    task automatic give_block(input logic [63:0] base);
        logic [1343:0] b;
        make_block(base, b);
        block_in = b;
        block_valid_i = 1'b1;
        @(negedge clk);
        block_valid_i = 1'b0;
        block_in = '0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({valid_o, last_o, block_ready_o, squeeze_req_o, busy_o} !== 5'b0
            || data_o !== 64'h0) begin
            fails++;
            $display("FAIL reset: v=%b l=%b br=%b sq=%b busy=%b data=%h, want all 0",
                     valid_o, last_o, block_ready_o, squeeze_req_o, busy_o, data_o);
        end
    endtask

    task automatic test_shake128_short;
        int sq0;
        sq0 = sq_cnt;
        start_job(2'b00, 16'd3);
        checks++;
        if (block_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL s128_wait: br=%b busy=%b want 1 1", block_ready_o, busy_o);
        end
        give_block(64'h1);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'(i + 1) || last_o !== (i == 2)) begin
                fails++;
                $display("FAIL s128_word%0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                         i, valid_o, data_o, last_o, 64'(i + 1), (i == 2));
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || last_o !== 1'b0 || data_o !== 64'h3) begin
            fails++;
            $display("FAIL s128_end: busy=%b v=%b last=%b data=%h want 0 0 0 3",
                     busy_o, valid_o, last_o, data_o);
        end
        checks++;
        if (sq_cnt != sq0) begin
            fails++;
            $display("FAIL s128_noreq: pulses=%0d want 0", sq_cnt - sq0);
        end
    endtask

    task automatic test_shake256_split;
        int sq0;
        sq0 = sq_cnt;
        start_job(2'b01, 16'd20);
        give_block(64'h100);
        ready_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'h100 + 64'(i) || last_o !== 1'b0) begin
                fails++;
                $display("FAIL s256_a%0d: v=%b data=%h last=%b want v=1 data=%h last=0",
                         i, valid_o, data_o, last_o, 64'h100 + 64'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (squeeze_req_o !== 1'b1 || block_ready_o !== 1'b1 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL s256_refill: sq=%b br=%b v=%b want 1 1 0",
                     squeeze_req_o, block_ready_o, valid_o);
        end
        give_block(64'h200);
        checks++;
        if (squeeze_req_o !== 1'b0) begin
            fails++;
            $display("FAIL s256_pulse: sq=%b want 0 after one cycle", squeeze_req_o);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'h200 + 64'(i) || last_o !== (i == 2)) begin
                fails++;
                $display("FAIL s256_b%0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                         i, valid_o, data_o, last_o, 64'h200 + 64'(i), (i == 2));
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || sq_cnt - sq0 != 1) begin
            fails++;
            $display("FAIL s256_end: busy=%b pulses=%0d want 0 1", busy_o, sq_cnt - sq0);
        end
    endtask

    task automatic test_shake128_full;
        int sq0;
        sq0 = sq_cnt;
        start_job(2'b00, 16'd21);
        give_block(64'h300);
        ready_i = 1'b1;
        for (int i = 0; i < 21; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'h300 + 64'(i) || last_o !== (i == 20)) begin
                fails++;
                $display("FAIL s128full_%0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                         i, valid_o, data_o, last_o, 64'h300 + 64'(i), (i == 20));
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || sq_cnt != sq0) begin
            fails++;
            $display("FAIL s128full_end: busy=%b pulses=%0d want 0 0", busy_o, sq_cnt - sq0);
        end
    endtask

    task automatic test_shake256_tail;
        start_job(2'b01, 16'd21);
        give_block(64'h400);
        ready_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'h400 + 64'(i)) begin
                fails++;
                $display("FAIL s256tail_a%0d: v=%b data=%h want v=1 data=%h",
                         i, valid_o, data_o, 64'h400 + 64'(i));
            end
            @(negedge clk);
        end
        give_block(64'h500);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'h500 + 64'(i) || last_o !== (i == 3)) begin
                fails++;
                $display("FAIL s256tail_b%0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                         i, valid_o, data_o, last_o, 64'h500 + 64'(i), (i == 3));
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL s256tail_end: busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_backpressure;
        start_job(2'b00, 16'd4);
        give_block(64'h1);
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (data_o !== 64'(i + 1)) begin
                fails++;
                $display("FAIL bp_pre%0d: data=%h want %h", i, data_o, 64'(i + 1));
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'h3 || last_o !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall%0d: v=%b data=%h last=%b want 1 3 0",
                         k, valid_o, data_o, last_o);
            end
            @(negedge clk);
        end
        ready_i = 1'b1;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 64'h3) begin
            fails++;
            $display("FAIL bp_resume: v=%b data=%h want 1 3", valid_o, data_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 64'h4 || last_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_last: v=%b data=%h last=%b want 1 4 1", valid_o, data_o, last_o);
        end
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_end: busy=%b v=%b want 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_ignored_starts;
        start_job(2'b00, 16'd2);
        start_i = 1'b1;
        mode_i = 2'b01;
        out_len_i = 16'd7;
        @(negedge clk);
        start_i = 1'b0;
        mode_i = 2'b00;
        out_len_i = '0;
        checks++;
        if (block_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL busy_start: br=%b busy=%b want 1 1", block_ready_o, busy_o);
        end
        give_block(64'h600);
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== 64'h600 + 64'(i) || last_o !== (i == 1)) begin
                fails++;
                $display("FAIL busy_start_w%0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                         i, valid_o, data_o, last_o, 64'h600 + 64'(i), (i == 1));
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL busy_start_end: busy=%b want 0", busy_o);
        end
        start_job(2'b00, 16'd0);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || block_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_len: busy=%b br=%b want 0 0", busy_o, block_ready_o);
        end
    endtask

    task automatic test_reset_mid_job;
        logic [1343:0] b;
        start_job(2'b00, 16'd10);
        give_block(64'h10);
        ready_i = 1'b1;
        repeat (5) @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 64'h15) begin
            fails++;
            $display("FAIL rst_pre: v=%b data=%h want 1 15", valid_o, data_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({valid_o, last_o, block_ready_o, squeeze_req_o, busy_o} !== 5'b0
            || data_o !== 64'h0) begin
            fails++;
            $display("FAIL rst_mid: v=%b l=%b br=%b sq=%b busy=%b data=%h want all 0",
                     valid_o, last_o, block_ready_o, squeeze_req_o, busy_o, data_o);
        end
        @(negedge clk);
        rst = 1'b1;
        make_block(64'h900, b);
        block_in = b;
        block_valid_i = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || block_ready_o !== 1'b0 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_restart: busy=%b br=%b v=%b want 0 0 0",
                     busy_o, block_ready_o, valid_o);
        end
        block_valid_i = 1'b0;
        block_in = '0;
        ready_i = 1'b0;
    endtask

    task automatic test_abort;
        logic [1343:0] b;
        start_job(2'b00, 16'd3);
        make_block(64'h800, b);
        block_in = b;
        block_valid_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        block_valid_i = 1'b0;
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || block_ready_o !== 1'b0 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_wait: busy=%b br=%b v=%b want 0 0 0",
                     busy_o, block_ready_o, valid_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_hold: v=%b busy=%b want 0 0", valid_o, busy_o);
        end
        start_job(2'b00, 16'd3);
        give_block(64'h700);
        ready_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || last_o !== 1'b0 || busy_o !== 1'b0
            || data_o !== 64'h700) begin
            fails++;
            $display("FAIL abort_dump: v=%b last=%b busy=%b data=%h want 0 0 0 700",
                     valid_o, last_o, busy_o, data_o);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_shake128_short;
        test_shake256_split;
        test_shake128_full;
        test_shake256_tail;
        test_backpressure;
        test_ignored_starts;
        test_reset_mid_job;
        test_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
